// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / hazard unit.
//   slot_t  : one entry of the in-flight result history (valid, rd, is_load, data)
//   SEL_*   : per-source operand-select codes reported on src_sel_o
// The slot struct is sized by FWD_XLEN / FWD_REG_AW; the top-level XLEN and
// REG_AW parameters default to these, so a wider datapath changes them here.
package fwd_pkg;

    localparam int FWD_XLEN   = 32;
    localparam int FWD_REG_AW = 5;

    localparam logic [1:0] SEL_RF  = 2'b00;  // register file read data
    localparam logic [1:0] SEL_OLD = 2'b01;  // an older history slot (index >= 1)
    localparam logic [1:0] SEL_S0  = 2'b10;  // slot 0 (EX/MEM) ALU result
    localparam logic [1:0] SEL_IMM = 2'b11;  // immediate

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic                  is_load;
        logic [FWD_XLEN-1:0]   data;
    } slot_t;

endpackage

// File: rtl/fwd_operand_sel.sv
// Combinational operand resolution for one EX source.
// Ports:
//   src_idx / src_rf        source register index and its register-file data
//   use_imm / imm           immediate select and value
//   slot_valid/rd/data      flattened history, slot 0 = youngest (EX/MEM)
//   slot0_is_load           slot 0 holds a load whose data is not yet available
//   src_data / src_sel      resolved operand and where it came from
//   stall                   this source needs the load still in slot 0
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic [REG_AW-1:0]       src_idx,
    input  logic [XLEN-1:0]         src_rf,
    input  logic                    use_imm,
    input  logic [XLEN-1:0]         imm,
    input  logic [DEPTH-1:0]        slot_valid,
    input  logic [DEPTH*REG_AW-1:0] slot_rd,
    input  logic                    slot0_is_load,
    input  logic [DEPTH*XLEN-1:0]   slot_data,
    output logic [XLEN-1:0]         src_data,
    output logic [1:0]              src_sel,
    output logic                    stall
);

    logic [DEPTH-1:0] hit;
    logic             old_hit;
    logic [XLEN-1:0]  old_data;

    // r0 is hardwired zero, so a zero index can never match a slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = slot_valid[gi]
                           && (src_idx != '0)
                           && (slot_rd[gi*REG_AW +: REG_AW] == src_idx);
        end
    endgenerate

    // Scan oldest to youngest so the lowest matching index >= 1 is kept.
    always_comb begin
        old_hit  = 1'b0;
        old_data = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (hit[k]) begin
                old_hit  = 1'b1;
                old_data = slot_data[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        src_data = src_rf;
        src_sel  = SEL_RF;
        stall    = 1'b0;
        if (use_imm) begin
            src_data = imm;
            src_sel  = SEL_IMM;
        end else if (hit[0] && slot0_is_load) begin
            // Load data only exists at the end of MEM: stall rather than
            // fall back to an older (stale) slot. Operand is don't-care.
            stall = 1'b1;
        end else if (hit[0]) begin
            src_data = slot_data[XLEN-1:0];
            src_sel  = SEL_S0;
        end else if (old_hit) begin
            src_data = old_data;
            src_sel  = SEL_OLD;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Depth-generic forwarding and load-use hazard unit for the EX stage.
// Keeps a shift history of in-flight results and resolves NSRC operands
// from it, from the register file, or from an immediate.
// Ports:
//   clk_i, rst_i (synchronous, active-low)
//   hold_i            freeze the history
//   flush_i           squash the EX instruction (it enters as a bubble)
//   ex_*              EX instruction: valid, writes, is load, rd, ALU result
//   mem_load_data_i   load data for the slot 0 instruction
//   src_*_i           per-source index, RF data, immediate select, immediate
//   src_data_o/src_sel_o  resolved operand and its source code per source
//   stall_o           load-use stall request
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int XLEN   = FWD_XLEN,
    parameter int REG_AW = FWD_REG_AW,
    parameter int DEPTH  = 2,
    parameter int NSRC   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hold_i,
    input  logic                   flush_i,
    input  logic                   ex_valid_i,
    input  logic                   ex_we_i,
    input  logic                   ex_is_load_i,
    input  logic [REG_AW-1:0]      ex_rd_i,
    input  logic [XLEN-1:0]        ex_result_i,
    input  logic [XLEN-1:0]        mem_load_data_i,
    input  logic [NSRC*REG_AW-1:0] src_idx_i,
    input  logic [NSRC*XLEN-1:0]   src_rf_i,
    input  logic [NSRC-1:0]        src_use_imm_i,
    input  logic [NSRC*XLEN-1:0]   src_imm_i,
    output logic [NSRC*XLEN-1:0]   src_data_o,
    output logic [NSRC*2-1:0]      src_sel_o,
    output logic                   stall_o
);

    slot_t slot_reg  [DEPTH];
    slot_t slot_next [DEPTH];

    logic [DEPTH-1:0]        slot_valid;
    logic [DEPTH*REG_AW-1:0] slot_rd;
    logic [DEPTH*XLEN-1:0]   slot_data;
    logic [NSRC-1:0]         stall_vec;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            slot_next[k] = slot_reg[k];
        end
        if (!hold_i) begin
            // A stalled or flushed EX instruction enters as a bubble; on a
            // stall the pipeline re-presents it next cycle.
            slot_next[0].valid   = ex_valid_i & ex_we_i & ~stall_o & ~flush_i;
            slot_next[0].rd      = ex_rd_i;
            slot_next[0].is_load = ex_is_load_i;
            slot_next[0].data    = ex_result_i;
            // Leaving MEM, a load swaps its address for the loaded value.
            slot_next[1] = slot_reg[0];
            if (slot_reg[0].is_load) begin
                slot_next[1].data = mem_load_data_i;
            end
            for (int k = 2; k < DEPTH; k++) begin
                slot_next[k] = slot_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_reg[k] <= slot_next[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign slot_valid[gi]                 = slot_reg[gi].valid;
            assign slot_rd[gi*REG_AW +: REG_AW]   = slot_reg[gi].rd;
            assign slot_data[gi*XLEN +: XLEN]     = slot_reg[gi].data;
        end

        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            fwd_operand_sel #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH)
            ) u_sel (
                .src_idx       (src_idx_i[gi*REG_AW +: REG_AW]),
                .src_rf        (src_rf_i[gi*XLEN +: XLEN]),
                .use_imm       (src_use_imm_i[gi]),
                .imm           (src_imm_i[gi*XLEN +: XLEN]),
                .slot_valid    (slot_valid),
                .slot_rd       (slot_rd),
                .slot0_is_load (slot_reg[0].is_load),
                .slot_data     (slot_data),
                .src_data      (src_data_o[gi*XLEN +: XLEN]),
                .src_sel       (src_sel_o[gi*2 +: 2]),
                .stall         (stall_vec[gi])
            );
        end
    endgenerate

    assign stall_o = |stall_vec;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios followed by
// randomized traffic, all compared against a history-list reference model.
module tb_fwd_hazard_unit;

    localparam int XW = 32;
    localparam int AW = 5;
    localparam int D  = 3;
    localparam int NS = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             hold, flush;
    logic             ex_valid, ex_we, ex_is_load;
    logic [AW-1:0]    ex_rd;
    logic [XW-1:0]    ex_result, mem_load;
    logic [NS*AW-1:0] src_idx;
    logic [NS*XW-1:0] src_rf, src_imm;
    logic [NS-1:0]    src_use_imm;
    logic [NS*XW-1:0] src_data;
    logic [NS*2-1:0]  src_sel;
    logic             stall;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.XLEN(XW), .REG_AW(AW), .DEPTH(D), .NSRC(NS)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .hold_i          (hold),
        .flush_i         (flush),
        .ex_valid_i      (ex_valid),
        .ex_we_i         (ex_we),
        .ex_is_load_i    (ex_is_load),
        .ex_rd_i         (ex_rd),
        .ex_result_i     (ex_result),
        .mem_load_data_i (mem_load),
        .src_idx_i       (src_idx),
        .src_rf_i        (src_rf),
        .src_use_imm_i   (src_use_imm),
        .src_imm_i       (src_imm),
        .src_data_o      (src_data),
        .src_sel_o       (src_sel),
        .stall_o         (stall)
    );

    // Reference model: list of in-flight writers, index 0 = youngest.
    typedef struct {
        bit          v;
        int unsigned rd;
        bit          ld;
        logic [31:0] d;
    } ent_t;

    ent_t        hist [D];
    logic [31:0] exp_data [NS];
    logic [1:0]  exp_sel  [NS];
    logic        exp_stall;
    int          n_run  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    // The youngest in-flight writer of a register decides the operand; a
    // load still in its first slot has no data yet and forces a stall.
    task automatic compute_expected();
        exp_stall = 1'b0;
        for (int s = 0; s < NS; s++) begin
            int unsigned idx;
            int          young;
            idx         = src_idx[s*AW +: AW];
            exp_data[s] = src_rf[s*XW +: XW];
            exp_sel[s]  = 2'b00;
            young       = -1;
            if (src_use_imm[s]) begin
                exp_data[s] = src_imm[s*XW +: XW];
                exp_sel[s]  = 2'b11;
            end else begin
                for (int k = 0; k < D; k++)
                    if (young < 0 && hist[k].v && idx != 0 && hist[k].rd == idx) young = k;
                if (young == 0 && hist[0].ld) begin
                    exp_stall = 1'b1;
                end else if (young == 0) begin
                    exp_data[s] = hist[0].d;
                    exp_sel[s]  = 2'b10;
                end else if (young > 0) begin
                    exp_data[s] = hist[young].d;
                    exp_sel[s]  = 2'b01;
                end
            end
        end
    endtask

    task automatic model_update();
        compute_expected();
        if (!rst) begin
            for (int k = 0; k < D; k++) hist[k] = '{v: 1'b0, rd: 0, ld: 1'b0, d: '0};
        end else if (!hold) begin
            for (int k = D - 1; k >= 1; k--) hist[k] = hist[k-1];
            if (hist[1].ld) hist[1].d = mem_load;
            hist[0] = '{v: ex_valid && ex_we && !exp_stall && !flush,
                        rd: ex_rd, ld: ex_is_load, d: ex_result};
        end
    endtask

    task automatic model_check();
        compute_expected();
        for (int s = 0; s < NS; s++) begin
            check_eq($sformatf("model_data%0d", s), src_data[s*XW +: XW], exp_data[s]);
            check_eq($sformatf("model_sel%0d", s), 32'(src_sel[s*2 +: 2]), 32'(exp_sel[s]));
        end
        check_eq("model_stall", 32'(stall), 32'(exp_stall));
    endtask

    task automatic look();
        @(negedge clk);
        model_check();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic expect_src(input int s, input logic [1:0] sel, input logic [31:0] data);
        check_eq($sformatf("dir_sel%0d", s), 32'(src_sel[s*2 +: 2]), 32'(sel));
        check_eq($sformatf("dir_data%0d", s), src_data[s*XW +: XW], data);
    endtask

    task automatic set_ex(input bit v, input bit we, input bit ld, input int rd, input logic [31:0] res);
        ex_valid   = v;
        ex_we      = we;
        ex_is_load = ld;
        ex_rd      = AW'(rd);
        ex_result  = res;
    endtask

    task automatic set_src(input int s, input int idx, input logic [31:0] rfv, input bit ui, input logic [31:0] im);
        src_idx[s*AW +: AW] = AW'(idx);
        src_rf[s*XW +: XW]  = rfv;
        src_use_imm[s]      = ui;
        src_imm[s*XW +: XW] = im;
    endtask

    task automatic clear_srcs();
        for (int s = 0; s < NS; s++) set_src(s, 0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; flush = 1'b0; mem_load = '0;
        set_ex(0, 0, 0, 0, 0);
        clear_srcs();

        // Reset with empty history
        set_src(0, 5, 32'h11, 0, 0);
        set_src(1, 6, 32'h22, 0, 0);
        step(); step();
        look();
        expect_src(0, 2'b00, 32'h11);
        expect_src(1, 2'b00, 32'h22);
        check_eq("reset_stall", 32'(stall), 32'h0);
        rst = 1'b1;
        step();

        // ALU result forwarded from slot 0, then from an older slot
        clear_srcs();
        set_ex(1, 1, 0, 5, 32'hAAAA);
        look(); step();
        set_ex(0, 0, 0, 0, 0);
        set_src(0, 5, 32'h1, 0, 0);
        look(); expect_src(0, 2'b10, 32'hAAAA); step();
        look(); expect_src(0, 2'b01, 32'hAAAA); step();

        // Load-use: one stall cycle, then load data via older slot
        clear_srcs();
        set_ex(1, 1, 1, 7, 32'h1000);
        look(); step();
        set_ex(1, 1, 0, 8, 32'h123);
        set_src(0, 7, 32'h2, 0, 0);
        mem_load = 32'hBEEF;
        look(); check_eq("lu_stall_on", 32'(stall), 32'h1); expect_src(0, 2'b00, 32'h2); step();
        look(); check_eq("lu_stall_off", 32'(stall), 32'h0); expect_src(0, 2'b01, 32'hBEEF); step();

        // Writes to r0 never forward; youngest of two r3 writes wins
        clear_srcs();
        set_ex(1, 1, 0, 0, 32'h77); look(); step();
        set_ex(1, 1, 0, 3, 32'h1);  look(); step();
        set_ex(1, 1, 0, 3, 32'h2);  look(); step();
        set_ex(0, 0, 0, 0, 0);
        set_src(0, 3, 32'h9, 0, 0);
        set_src(1, 0, 32'h0, 0, 0);
        look(); expect_src(0, 2'b10, 32'h2); expect_src(1, 2'b00, 32'h0); step();

        // Hold freezes slot 0; a flushed writer never forwards
        clear_srcs();
        set_ex(1, 1, 0, 9, 32'h55); look(); step();
        hold = 1'b1;
        set_ex(1, 1, 0, 10, 32'h99);
        set_src(0, 9, 32'h3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            look(); expect_src(0, 2'b10, 32'h55); step();
        end
        hold = 1'b0;
        clear_srcs();
        flush = 1'b1;
        set_ex(1, 1, 0, 11, 32'h66); look(); step();
        flush = 1'b0;
        set_ex(0, 0, 0, 0, 0);
        set_src(0, 11, 32'h4, 0, 0);
        look(); expect_src(0, 2'b00, 32'h4); step();
        look(); expect_src(0, 2'b00, 32'h4); step();

        // Immediate beats a matching load; stall stays low
        clear_srcs();
        set_ex(1, 1, 1, 12, 32'h2000); look(); step();
        set_ex(0, 0, 0, 0, 0);
        set_src(0, 12, 32'h5, 1, 32'h40);
        look(); expect_src(0, 2'b11, 32'h40); check_eq("imm_stall", 32'(stall), 32'h0); step();

        // Flush while stalled, then mid-run reset discards history
        clear_srcs();
        set_ex(1, 1, 1, 15, 32'h3000); look(); step();
        flush = 1'b1; mem_load = 32'hCAFE;
        set_ex(1, 1, 0, 16, 32'h16);
        set_src(0, 15, 32'h6, 0, 0);
        look(); check_eq("flush_stall", 32'(stall), 32'h1); step();
        flush = 1'b0;
        clear_srcs();
        set_ex(1, 1, 0, 13, 32'h13); look(); step();
        rst = 1'b0;
        set_ex(1, 1, 0, 14, 32'h14); look(); step();
        rst = 1'b1;
        set_ex(0, 0, 0, 0, 0);
        set_src(0, 13, 32'hA, 0, 0);
        set_src(1, 14, 32'hB, 0, 0);
        look(); expect_src(0, 2'b00, 32'hA); expect_src(1, 2'b00, 32'hB); step();

        // Randomized traffic over a small register range
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 49) != 0);
            hold  = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom);
            mem_load = $urandom;
            for (int s = 0; s < NS; s++)
                set_src(s, $urandom_range(0, 7), $urandom, $urandom_range(0, 4) == 0, $urandom);
            look();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
